// File: rtl/scrambler_tx_ctrl_if.sv
// Symbol bus between the ordered-set mux (master) and the per-lane TX scrambler (slave).
interface scrambler_tx_ctrl_if #(
  parameter int MAX_SYMBOLS = 4
);
  logic                     turn_off;
  logic [5:0]               pipe_width;
  logic                     in_valid;
  logic [8*MAX_SYMBOLS-1:0] in_data;
  logic [MAX_SYMBOLS-1:0]   in_datak;
  logic                     out_valid;
  logic [8*MAX_SYMBOLS-1:0] out_data;
  logic [MAX_SYMBOLS-1:0]   out_datak;
  logic [1:0]               lfsr_sel;

  modport master (
    output turn_off, pipe_width, in_valid, in_data, in_datak,
    input  out_valid, out_data, out_datak, lfsr_sel
  );

  modport slave (
    input  turn_off, pipe_width, in_valid, in_data, in_datak,
    output out_valid, out_data, out_datak, lfsr_sel
  );
endinterface

// File: rtl/scrambler_tx_ctrl.sv
// Per-lane Gen1/Gen2 TX scrambler: 1/2/4 symbols per beat, running LFSR chained lane to lane,
// COM reseeds, SKP holds, other K symbols advance. One registered stage.
module scrambler_tx_ctrl #(
  parameter int          MAX_SYMBOLS = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hFFFF,
  parameter logic [7:0]  COM_SYM     = 8'hBC,
  parameter logic [7:0]  SKP_SYM     = 8'h1C
) (
  input  logic clk,
  input  logic reset_n,
  scrambler_tx_ctrl_if.slave bus
);

  // Returns {lfsr_after_8_steps, scrambled_byte}; bits processed LSB first.
  function automatic logic [23:0] scramble_byte(input logic [15:0] lfsr_in, input logic [7:0] din);
    logic [15:0] l;
    logic [7:0]  d;
    l = lfsr_in;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      d[b] = din[b] ^ l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, d};
  endfunction

  logic [15:0]              lfsr_p1;
  logic                     vld_p1;
  logic [8*MAX_SYMBOLS-1:0] data_p1;
  logic [MAX_SYMBOLS-1:0]   datak_p1;
  logic [1:0]               sel_p1;

  int                       nsym_p0;
  logic [1:0]               sel_p0;
  logic [15:0]              run_p0;
  logic [15:0]              lfsr_nxt_p0;
  logic [23:0]              sr_p0;
  logic [7:0]               sym_p0;
  logic [8*MAX_SYMBOLS-1:0] data_p0;
  logic [MAX_SYMBOLS-1:0]   datak_p0;

  // Stage p0: lane-serial scramble of the incoming beat
  always_comb begin
    nsym_p0     = MAX_SYMBOLS;
    sel_p0      = 2'd2;
    run_p0      = lfsr_p1;
    sr_p0       = '0;
    sym_p0      = '0;
    data_p0     = '0;
    datak_p0    = '0;
    lfsr_nxt_p0 = lfsr_p1;

    case (bus.pipe_width)
      6'd8:    begin nsym_p0 = 1; sel_p0 = 2'd0; end
      6'd16:   begin nsym_p0 = 2; sel_p0 = 2'd1; end
      6'd32:   nsym_p0 = 4;
      default: nsym_p0 = MAX_SYMBOLS;
    endcase
    if (nsym_p0 > MAX_SYMBOLS) nsym_p0 = MAX_SYMBOLS;

    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (i < nsym_p0) begin
        sym_p0      = bus.in_data[8*i +: 8];
        datak_p0[i] = bus.in_datak[i];
        if (bus.turn_off) begin
          data_p0[8*i +: 8] = sym_p0;
        end else if (bus.in_datak[i]) begin
          data_p0[8*i +: 8] = sym_p0;
          if (sym_p0 == COM_SYM) begin
            run_p0 = LFSR_SEED;
          end else if (sym_p0 != SKP_SYM) begin
            sr_p0  = scramble_byte(run_p0, 8'h00);
            run_p0 = sr_p0[23:8];
          end
        end else begin
          sr_p0             = scramble_byte(run_p0, sym_p0);
          run_p0            = sr_p0[23:8];
          data_p0[8*i +: 8] = sr_p0[7:0];
        end
      end
    end

    if (bus.turn_off)      lfsr_nxt_p0 = LFSR_SEED;
    else if (bus.in_valid) lfsr_nxt_p0 = run_p0;
  end

  // Stage p1: output register; data holds across invalid cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_p1  <= LFSR_SEED;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      datak_p1 <= '0;
      sel_p1   <= 2'd2;
    end else begin
      lfsr_p1 <= lfsr_nxt_p0;
      vld_p1  <= bus.in_valid;
      sel_p1  <= sel_p0;
      if (bus.in_valid) begin
        data_p1  <= data_p0;
        datak_p1 <= datak_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_datak = datak_p1;
  assign bus.lfsr_sel  = sel_p1;

endmodule

// File: tb/tb_scrambler_tx_ctrl.sv
// Bench for scrambler_tx_ctrl: directed test-plan steps, then random beats against a
// keystream-position reference model.
module tb_scrambler_tx_ctrl;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  scrambler_tx_ctrl_if #(.MAX_SYMBOLS(MAXS)) bus ();

  scrambler_tx_ctrl #(.MAX_SYMBOLS(MAXS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Model: keystream byte p is what the scrambler XORs after p advancing symbols since seed.
  logic [7:0]  ks [65535];
  int          m_idx;
  logic        m_vld;
  logic [31:0] m_data;
  logic [3:0]  m_datak;
  logic [1:0]  m_sel;
  int          ntests = 0;
  int          nfail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_ks();
    logic [15:0] l;
    logic [7:0]  by;
    l = 16'hFFFF;
    for (int p = 0; p < 65535; p++) begin
      by = '0;
      for (int b = 0; b < 8; b++) begin
        by[b] = l[15];
        l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
      end
      ks[p] = by;
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_vld = 1'b0; m_data = '0; m_datak = '0; m_sel = 2'd2;
  endtask

  task automatic model_beat();
    int n;
    int run;
    logic [7:0] sym;
    logic [5:0] pw;
    pw    = bus.pipe_width;
    m_sel = (pw == 6'd8) ? 2'd0 : (pw == 6'd16) ? 2'd1 : 2'd2;
    n     = (pw == 6'd8) ? 1 : (pw == 6'd16) ? 2 : (pw == 6'd32) ? 4 : MAXS;
    if (n > MAXS) n = MAXS;
    run = m_idx;
    if (bus.in_valid) begin
      m_data  = '0;
      m_datak = '0;
      for (int i = 0; i < n; i++) begin
        sym        = bus.in_data[8*i +: 8];
        m_datak[i] = bus.in_datak[i];
        if (bus.turn_off) begin
          m_data[8*i +: 8] = sym;
        end else if (bus.in_datak[i]) begin
          m_data[8*i +: 8] = sym;
          if (sym == 8'hBC)      run = 0;
          else if (sym != 8'h1C) run = (run + 1) % 65535;
        end else begin
          m_data[8*i +: 8] = sym ^ ks[run];
          run = (run + 1) % 65535;
        end
      end
    end
    m_vld = bus.in_valid;
    if (bus.turn_off)      m_idx = 0;
    else if (bus.in_valid) m_idx = run;
  endtask

  task automatic drive(input logic v, input logic t, input logic [5:0] pw,
                       input logic [31:0] d, input logic [3:0] k);
    bus.in_valid = v; bus.turn_off = t; bus.pipe_width = pw;
    bus.in_data = d;  bus.in_datak = k;
  endtask

  task automatic cycle(input string tag);
    if (!reset_n) model_reset();
    else          model_beat();
    @(posedge clk);
    #1;
    check({tag, ".vld"},   {31'd0, bus.out_valid}, {31'd0, m_vld});
    check({tag, ".data"},  bus.out_data,           m_data);
    check({tag, ".datak"}, {28'd0, bus.out_datak}, {28'd0, m_datak});
    check({tag, ".sel"},   {30'd0, bus.lfsr_sel},  {30'd0, m_sel});
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  k;
    logic [5:0]  pw;
    build_ks();
    drive(1'b1, 1'b0, 6'd16, 32'h1234_5678, 4'hF);
    reset_n = 1'b0;
    cycle("reset0");
    cycle("reset1");
    check("reset_data_zero", bus.out_data, 32'h0);
    reset_n = 1'b1;

    // Width 8: COM then three zero data bytes; upper lanes carry junk that must be ignored
    drive(1'b1, 1'b0, 6'd8, 32'hA5A5_A5BC, 4'b1111); cycle("w8_com");
    check("w8_com_lit", bus.out_data, 32'h0000_00BC);
    drive(1'b1, 1'b0, 6'd8, 32'hA5A5_A500, 4'b1110); cycle("w8_d0");
    check("w8_d0_lit", bus.out_data, 32'h0000_00FF);
    cycle("w8_d1");
    check("w8_d1_lit", bus.out_data, 32'h0000_0017);
    cycle("w8_d2");
    check("w8_d2_lit", bus.out_data, 32'h0000_00C0);

    // Width 32: COM reseeds inside the beat
    drive(1'b1, 1'b0, 6'd32, 32'h0000_00BC, 4'b0001); cycle("w32");
    check("w32_lit", bus.out_data, 32'hC017_FFBC);

    // Width 16 with SKP holding the LFSR
    drive(1'b1, 1'b0, 6'd16, 32'hEEEE_1CBC, 4'b1111); cycle("w16_b0");
    check("w16_b0_lit", bus.out_data, 32'h0000_1CBC);
    drive(1'b1, 1'b0, 6'd16, 32'h0000_1C00, 4'b0010); cycle("w16_b1");
    check("w16_b1_lit", bus.out_data, 32'h0000_1CFF);
    drive(1'b1, 1'b0, 6'd16, 32'h0000_0000, 4'b0000); cycle("w16_b2");
    check("w16_b2_lit", bus.out_data, 32'h0000_C017);

    // turn_off: pass-through, then scrambling resumes from seed after COM
    drive(1'b1, 1'b1, 6'd8, 32'h0000_004A, 4'b0000); cycle("toff_d");
    check("toff_d_lit", bus.out_data, 32'h0000_004A);
    drive(1'b1, 1'b1, 6'd8, 32'h0000_00BC, 4'b0001); cycle("toff_com");
    drive(1'b1, 1'b0, 6'd8, 32'h0000_00BC, 4'b0001); cycle("ton_com");
    drive(1'b1, 1'b0, 6'd8, 32'h0000_0000, 4'b0000); cycle("ton_d");
    check("ton_d_lit", bus.out_data, 32'h0000_00FF);

    // in_valid gaps hold the LFSR and the output bytes
    drive(1'b1, 1'b0, 6'd8, 32'h0000_00BC, 4'b0001); cycle("gap_com");
    drive(1'b1, 1'b0, 6'd8, 32'h0000_0000, 4'b0000); cycle("gap_d0");
    drive(1'b0, 1'b0, 6'd8, 32'h0000_0077, 4'b0000);
    for (int g = 0; g < 3; g++) begin
      cycle("gap_idle");
      check("gap_hold_lit", bus.out_data, 32'h0000_00FF);
    end
    drive(1'b1, 1'b0, 6'd8, 32'h0000_0000, 4'b0000); cycle("gap_d1");
    check("gap_d1_lit", bus.out_data, 32'h0000_0017);

    // Reset mid-stream discards the beat and reseeds
    drive(1'b1, 1'b0, 6'd8, 32'h0000_00BC, 4'b0001); cycle("rst_com");
    drive(1'b1, 1'b0, 6'd8, 32'h0000_0000, 4'b0000); cycle("rst_d0");
    cycle("rst_d1");
    reset_n = 1'b0; cycle("rst_mid");
    check("rst_mid_vld", {31'd0, bus.out_valid}, 32'd0);
    reset_n = 1'b1;
    cycle("rst_after");
    check("rst_after_lit", bus.out_data, 32'h0000_00FF);

    // Random beats: widths (incl. illegal), K mix, turn_off, gaps, occasional reset
    for (int it = 0; it < 600; it++) begin
      reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      case ($urandom_range(0, 4))
        0:       pw = 6'd8;
        1:       pw = 6'd16;
        2, 3:    pw = 6'd32;
        default: pw = 6'($urandom_range(0, 63));
      endcase
      d = $urandom;
      k = '0;
      for (int i = 0; i < MAXS; i++) begin
        case ($urandom_range(0, 9))
          0: begin k[i] = 1'b1; d[8*i +: 8] = 8'hBC; end
          1: begin k[i] = 1'b1; d[8*i +: 8] = 8'h1C; end
          2: k[i] = 1'b1;
          3: d[8*i +: 8] = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'h1C;
          default: ;
        endcase
      end
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, pw, d, k);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
